// File: rtl/display_uart_tx.sv
// display_uart_tx
//   Streams a snapshot of the display character slots out as 8N1 UART so a
//   host terminal can mirror the CPU's display line. On an accepted start the
//   slot data and clamped length are captured. The selected bytes are then sent
//   slot 0 first, optionally followed by CR LF.
//
// Ports
//   clock       system clock, all state changes on posedge
//   reset       synchronous, active-low reset
//   start       frame request, only looked at while idle
//   frame_data  N_CHARS byte slots, slot i = bits [8*i+7:8*i]
//   frame_len   number of slots to send (clamped to N_CHARS), sampled with start
//   tx          registered UART line, idle high
//   busy        high from accept until the frame completes
//   done        one-cycle pulse when the last stop bit ends
//   char_index  slot index of the byte on the line (CR = N_CHARS, LF = N_CHARS+1)

module display_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_CHARS      = 16,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*N_CHARS-1:0] frame_data,
    input  logic [4:0]           frame_len,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           char_index
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // The byte index is kept one bit wider than the port so that the LF slot
    // stays distinct from slot 0 even when N_CHARS = 31.
    localparam logic [5:0]     CR_IDX    = 6'(N_CHARS);
    localparam logic [5:0]     LF_IDX    = 6'(N_CHARS + 1);
    localparam logic [4:0]     MAX_LEN   = 5'(N_CHARS);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT
    } state_t;

    state_t               state, state_d;
    logic [BW-1:0]        baud, baud_d;
    logic [2:0]           bit_cnt, bit_cnt_d;
    logic [7:0]           shift, shift_d;
    logic [5:0]           idx, idx_d;
    logic                 tx_d, busy_d, done_d;

    logic [8*N_CHARS-1:0] frame_snap;
    logic [4:0]           len_snap;
    logic                 snap;
    logic [4:0]           eff_len;
    logic [5:0]           nxt_idx;
    logic                 more;

    // Byte that belongs to a given index: a frame slot, or the CR/LF trailer.
    function automatic logic [7:0] byte_of(input logic [8*N_CHARS-1:0] f,
                                           input logic [5:0]           i);
        logic [7:0] b;
        b = 8'h00;
        if (i == CR_IDX) begin
            b = 8'h0D;
        end else if (i == LF_IDX) begin
            b = 8'h0A;
        end else begin
            for (int s = 0; s < N_CHARS; s++) begin
                if (i == 6'(s)) b = f[8*s +: 8];
            end
        end
        return b;
    endfunction

    // Which byte follows the current one, if any.
    always_comb begin
        nxt_idx = idx;
        more    = 1'b0;
        if (idx < CR_IDX) begin
            if (idx + 6'd1 < 6'(len_snap)) begin
                nxt_idx = idx + 6'd1;
                more    = 1'b1;
            end else if (APPEND_CRLF) begin
                nxt_idx = CR_IDX;
                more    = 1'b1;
            end
        end else if (idx == CR_IDX) begin
            nxt_idx = LF_IDX;
            more    = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state;
        baud_d    = baud;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        idx_d     = idx;
        tx_d      = tx;
        busy_d    = busy;
        done_d    = 1'b0;
        snap      = 1'b0;
        eff_len   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;

        case (state)
            IDLE: begin
                if (start) begin
                    snap = 1'b1;
                    if (eff_len == 5'd0 && !APPEND_CRLF) begin
                        // Nothing to send: acknowledge without touching the line.
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        idx_d   = (eff_len == 5'd0) ? CR_IDX : 6'd0;
                        shift_d = byte_of(frame_data, idx_d);
                        tx_d    = 1'b0;
                        baud_d  = '0;
                        state_d = START_BIT;
                    end
                end
            end
            START_BIT: begin
                if (baud == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift[0];
                    state_d   = DATA_BITS;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA_BITS: begin
                if (baud == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        shift_d   = shift >> 1;
                        tx_d      = shift[1];
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = NEXT;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            NEXT: begin
                if (more) begin
                    idx_d   = nxt_idx;
                    shift_d = byte_of(frame_snap, nxt_idx);
                    tx_d    = 1'b0;
                    state_d = START_BIT;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            idx     <= 6'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            idx     <= idx_d;
            tx      <= tx_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // NOTE: the snapshot is pure data, always written on accept before it is
    // read, so it carries no reset.
    always_ff @(posedge clock) begin
        if (snap) begin
            frame_snap <= frame_data;
            len_snap   <= eff_len;
        end
    end

    assign char_index = idx[4:0];

endmodule

// File: tb/tb_display_uart_tx.sv
// Self-checking bench for display_uart_tx. Two instances run side by side:
// dut 0 appends CR LF, dut 1 does not. Stimulus pushes the expected bytes
// and frame durations into queues. Per-instance monitors decode the serial
// line and the busy/done handshake, then pop and compare.

module tb_display_uart_tx;

    localparam int CPB    = 4;
    localparam int NC     = 16;
    localparam int PERIOD = 10 * CPB + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       start_v = '0;
    logic [1:0][127:0] frame_v = '0;
    logic [1:0][4:0]  len_v = '0;
    logic [1:0]       tx_v, busy_v, done_v;
    logic [1:0][4:0]  ci_v;

    // Expected bytes as {char_index, byte}, and expected busy length per frame.
    logic [12:0] exp_q [2][$];
    int          exp_frames [2][$];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    display_uart_tx #(.CLKS_PER_BIT(CPB), .N_CHARS(NC), .APPEND_CRLF(1'b1)) u_dut_crlf (
        .clock(clock), .reset(reset), .start(start_v[0]), .frame_data(frame_v[0]),
        .frame_len(len_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .char_index(ci_v[0])
    );

    display_uart_tx #(.CLKS_PER_BIT(CPB), .N_CHARS(NC), .APPEND_CRLF(1'b0)) u_dut_plain (
        .clock(clock), .reset(reset), .start(start_v[1]), .frame_data(frame_v[1]),
        .frame_len(len_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .char_index(ci_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: which bytes a frame request produces and how long busy stays high.
    task automatic expect_frame(input int g, input logic [127:0] f, input int len);
        int eff;
        int crlf;
        eff  = (len > NC) ? NC : len;
        crlf = (g == 0) ? 1 : 0;
        for (int i = 0; i < eff; i++) exp_q[g].push_back({5'(i), f[8*i +: 8]});
        if (crlf == 1) begin
            exp_q[g].push_back({5'(NC), 8'h0D});
            exp_q[g].push_back({5'(NC + 1), 8'h0A});
        end
        exp_frames[g].push_back((eff + 2 * crlf) * PERIOD);
    endtask

    task automatic issue(input int g, input logic [127:0] f, input int len);
        tick();
        frame_v[g] = f;
        len_v[g]   = 5'(len);
        start_v[g] = 1'b1;
        expect_frame(g, f, len);
        tick();
        start_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clock);
        while (busy_v[g] && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("idle_timeout dut%0d", g), busy_v[g], 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_state(input int g);
        check($sformatf("rst_tx dut%0d", g), tx_v[g], 1'b1);
        check($sformatf("rst_busy dut%0d", g), busy_v[g], 1'b0);
        check($sformatf("rst_done dut%0d", g), done_v[g], 1'b0);
        check($sformatf("rst_char_index dut%0d", g), ci_v[g], 5'd0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        // UART decoder: mid-bit sampling from the first low cycle of a start bit.
        initial begin : byte_mon
            bit         active;
            int         cyc;
            logic [7:0] sh;
            logic [4:0] ci0;
            active = 1'b0;
            cyc    = 0;
            sh     = 8'h00;
            ci0    = 5'd0;
            forever begin
                @(negedge clock);
                if (!reset) begin
                    active = 1'b0;
                end else if (!active) begin
                    if (tx_v[g] == 1'b0) begin
                        active = 1'b1;
                        cyc    = 0;
                        ci0    = ci_v[g];
                    end
                end else begin
                    cyc++;
                    if (cyc >= CPB && cyc < 9 * CPB && (cyc % CPB) == CPB / 2)
                        sh[cyc / CPB - 1] = tx_v[g];
                    if (cyc == 9 * CPB + CPB / 2) begin
                        active = 1'b0;
                        if (exp_q[g].size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL byte_unexpected dut%0d: got char_index=%0d byte=%02h, none expected",
                                     g, ci0, sh);
                        end else begin
                            check($sformatf("byte dut%0d {stop,char_index,byte}", g),
                                  {tx_v[g], ci0, sh}, {1'b1, exp_q[g].pop_front()});
                        end
                    end
                end
            end
        end

        // Handshake monitor: done must coincide with busy low, ending a busy run of the expected length.
        initial begin : frame_mon
            int bcnt;
            bcnt = 0;
            forever begin
                @(negedge clock);
                if (!reset) begin
                    bcnt = 0;
                end else if (done_v[g]) begin
                    if (exp_frames[g].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL done_unexpected dut%0d: got done after %0d busy cycles, none expected",
                                 g, bcnt);
                    end else begin
                        check($sformatf("frame dut%0d {busy,busy_cycles}", g),
                              {busy_v[g], 32'(bcnt)}, {1'b0, 32'(exp_frames[g].pop_front())});
                    end
                    bcnt = 0;
                end else if (busy_v[g]) begin
                    bcnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [39:0]  cap;
        logic [39:0]  want;
        logic [7:0]   c_byte;
        logic [9:0]   bits;
        logic [127:0] f;
        int           n;

        repeat (3) tick();
        @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        tick();
        reset = 1'b1;

        // Single 'c' on the plain instance, whole waveform compared cycle by cycle.
        c_byte = 8'h63;
        bits   = {1'b1, c_byte, 1'b0};
        for (int c = 0; c < 40; c++) want[c] = bits[c / CPB];
        issue(1, 128'h63, 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            cap[c] = tx_v[1];
        end
        check("single_char_tx_wave", cap, want);
        wait_idle(1);

        // "cu" with CR LF.
        issue(0, 128'h7563, 2);
        wait_idle(0);

        // Zero length, no trailer: immediate done, line untouched.
        issue(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 0);
        @(negedge clock);
        check("zero_len_done_pulse", done_v[1], 1'b1);
        check("zero_len_busy_low", busy_v[1], 1'b0);
        wait_idle(1);

        // Zero length with trailer: only CR LF.
        issue(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 0);
        wait_idle(0);

        // Clamp and snapshot: oversize length, data overwritten and start pulsed mid-frame.
        issue(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 31);
        repeat (100) tick();
        frame_v[0] = '1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_idle(0);

        // Random frames on both instances.
        for (int r = 0; r < 6; r++) begin
            issue(r % 2, {$urandom(), $urandom(), $urandom(), $urandom()}, int'($urandom_range(0, 31)));
            wait_idle(r % 2);
        end

        // Reset during data bit 3 of byte 1.
        issue(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 3);
        repeat (58) tick();
        reset = 1'b0;
        exp_q[0].delete();
        exp_frames[0].delete();
        tick();
        reset = 1'b1;
        @(negedge clock);
        check_reset_state(0);
        issue(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
        wait_idle(0);

        // Back-to-back: start held through done re-arms after one idle cycle.
        f = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        frame_v[1] = f;
        len_v[1]   = 5'd1;
        start_v[1] = 1'b1;
        expect_frame(1, f, 1);
        expect_frame(1, f, 1);
        n = 0;
        @(negedge clock);
        while (!done_v[1] && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("b2b_first_done", done_v[1], 1'b1);
        check("b2b_gap_busy_low", busy_v[1], 1'b0);
        @(negedge clock);
        check("b2b_rearm_busy_high", busy_v[1], 1'b1);
        tick();
        start_v[1] = 1'b0;
        wait_idle(1);

        repeat (5) tick();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("bytes_outstanding dut%0d", g), exp_q[g].size(), 0);
            check($sformatf("frames_outstanding dut%0d", g), exp_frames[g].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
- Downstream consumer of the datapath's display special-function registers: the character SFRs and the two hex_UTF8-converted number SFRs.
- Top level packs the low byte of each SFR into a frame. On a start request, this block snapshots the frame and streams it out as 8N1 UART, optionally followed by CR LF, so a host terminal shows the CPU's display line.
- Purely sequential: a byte sequencer wrapped around a bit-serialiser with a baud counter.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit; legal range 2..65535.
- N_CHARS, 16, number of byte slots in frame_data; legal range 1..31.
- APPEND_CRLF, 1, when 1, bytes 0x0D then 0x0A are sent after the last frame byte.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- frame_data  input  8*N_CHARS  character slots; slot i = bits [8*i+7:8*i], slot 0 sent first.
- frame_len  input  5  number of slots to send; sampled with start.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high from accept until frame complete.
- done  output  1  one-cycle pulse when the final stop bit ends.
- char_index  output  5  index of the byte currently on the line; CR = N_CHARS, LF = N_CHARS+1.

Behaviour:
- Reset (reset==0 at a posedge):
  - tx=1, busy=0, done=0, char_index=0; baud counter, bit counter and shift register cleared; state=IDLE.
  - Reset wins over every other input. Mid-frame reset abandons the frame; tx is 1 after that edge, even if it truncates a bit.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE, start==1 at edge k:
  - Latch frame_data and min(frame_len, N_CHARS) into internal registers.
  - If the effective length is 0 and APPEND_CRLF==0: busy stays 0, done=1 for the cycle after edge k, tx untouched, state stays IDLE.
  - Otherwise: busy=1, char_index = first byte index (0, or N_CHARS if length 0 with CRLF), shift register = that byte, tx=0 after edge k, state→START_BIT.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, then →DATA_BITS.
- DATA_BITS: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles, then →STOP_BIT with tx=1.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles, then →NEXT.
- NEXT (single cycle, tx=1):
  - If more bytes remain: advance char_index, load the next byte, →START_BIT.
  - Otherwise: busy=0 and done=1 on the same edge, →IDLE.
- Per-byte period: 10*CLKS_PER_BIT+1 cycles, including the NEXT cycle.
- Frame timing: busy rises at edge k and falls at edge k + B*(10*CLKS_PER_BIT+1), where B = effective length + 2*APPEND_CRLF.
- Live inputs: start, frame_data and frame_len are ignored while busy. Changes to frame_data after acceptance do not affect the frame in flight.
- Back-to-back frames: start held high through done re-arms. The new frame is accepted on the edge after busy falls (IDLE lasts one cycle).
- frame_len > N_CHARS is clamped to N_CHARS; no error flag.
- Baud counter width = ceil(log2(CLKS_PER_BIT)). It counts 0..CLKS_PER_BIT-1 and wraps exactly at the bit boundary, with no accumulated drift.
- tx is driven from a register, never combinationally.

Test Plan:
- Single char, CLKS_PER_BIT=4, APPEND_CRLF=0, N_CHARS=16, frame_len=1, slot0=0x63 ('c'):
  - tx = 0,1,1,0,0,0,1,1,0,1 (start, LSB-first data, stop), each held 4 cycles.
  - busy high 41 cycles; done pulses once as busy falls.
- CRLF, frame_len=2, slots "cu" (0x63, 0x75), APPEND_CRLF=1:
  - Decoded bytes 0x63, 0x75, 0x0D, 0x0A.
  - char_index sequence 0, 1, 16, 17; busy high 4*41 = 164 cycles.
- Zero length:
  - frame_len=0, APPEND_CRLF=0 → tx constantly 1, busy never rises, done pulses one cycle after start.
  - Same with APPEND_CRLF=1 → only 0x0D, 0x0A sent.
- Clamp and snapshot: frame_len=31 with N_CHARS=16; after accept, overwrite frame_data with 0xFF and pulse start mid-frame → exactly the 16 original bytes sent, extra start ignored, single done.
- Mid-frame reset: assert reset during data bit 3 of byte 1 → next edge tx=1, busy=0, done=0, char_index=0. A following start sends slot 0 correctly.
- Back-to-back: start held high for two frames of frame_len=1 → busy low for exactly 1 cycle between frames; two done pulses.
